pila_subrutinas: RTL and testbench
==================================

Name: pila_subrutinas

Overview:
- Hardware return-address stack for the single-cycle CPU; sits directly downstream of the control unit and consumes its push/pop strobes.
- On a call, the datapath presents PC+1 and the control unit asserts push. On a return, the control unit asserts pop and s_stack, and the PC mux takes d_out in the same cycle.
- d_out is therefore combinational from the registered stack state; all state changes occur on the rising clk edge.

Parameters:
- WIDTH, 10, width of a stored return address (matches the PC / jump-address field).
- DEPTH, 8, number of entries; must be a power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- push  in  1  store d_in on top of stack at next edge.
- pop  in  1  remove top entry at next edge; d_out is valid during this same cycle.
- d_in  in  WIDTH  return address to push (PC+1 from datapath).
- d_out  out  WIDTH  current top-of-stack entry; 0 when empty; combinational.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Storage: DEPTH×WIDTH register array, write pointer sp (log2 DEPTH bits, wraps modulo DEPTH), counter count.
- Storage contents are not reset.
- Reset (reset==0 at rising edge) has priority over push/pop:
  - sp=0, count=0, overflow=0, underflow=0.
  - Outputs after reset: d_out=0, empty=1, full=0.
- d_out = mem[sp-1] when count>0, else 0. The value reflects state before the pending edge, so a pop cycle reads the address being removed.
- push only, not full: mem[sp]<=d_in; sp<=sp+1; count<=count+1.
- pop only, not empty: sp<=sp-1; count<=count-1. Storage is untouched.
- push only, full: storage, sp and count are unchanged; overflow<=1 (see optional feature).
- pop only, empty: no state change; underflow<=1; d_out stays 0.
- push and pop in the same cycle:
  - Not empty: replace top. mem[sp-1]<=d_in; sp and count unchanged; no flags.
  - Empty: behaves as push only; underflow is not set.
- Neither push nor pop: state holds.
- overflow and underflow clear only on reset.
- Pointer width rule: sp arithmetic is modulo DEPTH. count saturates logically at 0..DEPTH and never wraps.
- Latency:
  - Pushed value is visible on d_out in the cycle after the push edge.
  - After a pop edge, d_out shows the next-older entry.
- Reset asserted mid-sequence discards all entries. The first pop after reset flags underflow.

Optional Feature:
- Macro: PILA_WRAP_EN.
- Defined: push when full overwrites the oldest entry (circular).
  - mem[sp]<=d_in; sp<=sp+1; count stays DEPTH; overflow<=1 still set.
  - Subsequent pops return the newest DEPTH addresses in LIFO order. The overwritten oldest entry is lost.
- Not defined: push when full is dropped as described in Behaviour; storage is unchanged.

Test Plan:
- Reset then idle: hold reset=0 for 2 edges, release -> empty=1, full=0, count=0, d_out=0, overflow=0, underflow=0.
- LIFO order: push 0x010, 0x020, 0x030 on consecutive cycles -> count=3, d_out=0x030. Pop ×3 -> d_out reads 0x030, 0x020, 0x010 during each pop cycle, then 0; empty=1, underflow=0.
- Full/overflow: push 0x001..0x008 (DEPTH=8) -> full=1. Push 0x3FF:
  - Without PILA_WRAP_EN: overflow=1, d_out=0x008, count=8.
  - With PILA_WRAP_EN: d_out=0x3FF, count=8; eight pops return 0x3FF, 0x008…0x002.
- Underflow: from reset, pop -> underflow=1, count=0, d_out=0. A following push of 0x055 gives d_out=0x055, underflow stays 1.
- Simultaneous push+pop:
  - Stack holds 0x011, 0x022: assert both with d_in=0x0AA -> count=2, d_out=0x0AA; pop -> d_out=0x0AA, then 0x011.
  - Same on an empty stack -> count=1, d_out=0x0AA, underflow=0.
- Reset mid-operation: push 0x100, 0x200; assert reset=0 together with push of 0x300 -> next cycle count=0, empty=1, d_out=0, flags 0.

Source files
------------

// File: rtl/pila_subrutinas.sv
// Hardware return-address stack for the single-cycle CPU (call pushes PC+1, return pops).
// Optional macro PILA_WRAP_EN: a push while full overwrites the oldest entry instead of being dropped.
module pila_subrutinas #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           d_in,
  output logic [WIDTH-1:0]           d_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             we_s;
  logic [PW-1:0]    waddr_s;
  logic [PW-1:0]    top_s;
  logic             empty_s;
  logic             full_s;

  assign top_s   = sp_q - PW'(1);
  assign empty_s = (count_q == CW'(0));
  assign full_s  = (count_q == CW'(DEPTH));

  // Next-state decode for pointer, occupancy, sticky flags and storage write.
  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    we_s        = 1'b0;
    waddr_s     = sp_q;
    case ({push, pop})
      2'b10: begin
        if (full_s) begin
          overflow_d = 1'b1;
`ifdef PILA_WRAP_EN
          we_s    = 1'b1;
          waddr_s = sp_q;
          sp_d    = sp_q + PW'(1);
`else
          we_s    = 1'b0;
`endif
        end else begin
          we_s    = 1'b1;
          waddr_s = sp_q;
          sp_d    = sp_q + PW'(1);
          count_d = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (empty_s) begin
          underflow_d = 1'b1;
        end else begin
          sp_d    = sp_q - PW'(1);
          count_d = count_q - CW'(1);
        end
      end
      2'b11: begin
        // Empty stack cannot be full, so the call side simply pushes.
        if (empty_s) begin
          we_s    = 1'b1;
          waddr_s = sp_q;
          sp_d    = sp_q + PW'(1);
          count_d = count_q + CW'(1);
        end else begin
          we_s    = 1'b1;
          waddr_s = top_s;
        end
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sp_q        <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents survive reset, but reset still blocks a concurrent write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= mem_q;
    end else if (we_s) begin
      mem_q[waddr_s] <= d_in;
    end else begin
      mem_q <= mem_q;
    end
  end

  assign d_out     = empty_s ? {WIDTH{1'b0}} : mem_q[top_s];
  assign empty     = empty_s;
  assign full      = full_s;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_pila_subrutinas.sv
// Self-checking bench for pila_subrutinas: queue-based reference model compared every cycle
// plus hand-computed literal expectations. Honors PILA_WRAP_EN like the design.
module tb_pila_subrutinas;

  localparam int WIDTH = 10;
  localparam int DEPTH = 8;

  logic             clk;
  logic             reset;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic             empty;
  logic             full;
  logic [3:0]       count;
  logic             overflow;
  logic             underflow;

  pila_subrutinas #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .d_in(d_in),
    .d_out(d_out), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  logic [WIDTH-1:0] mq[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_top();
    if (mq.size() == 0) return '0;
    return mq[mq.size()-1];
  endfunction

  // Reference model: stack as a queue, newest at the back.
  task automatic model_step(input bit p, input bit o, input logic [WIDTH-1:0] d, input bit r);
    if (!r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (p && o) begin
      if (mq.size() == 0) mq.push_back(d);
      else mq[mq.size()-1] = d;
    end else if (p) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else begin
        m_ovf = 1'b1;
`ifdef PILA_WRAP_EN
        void'(mq.pop_front());
        mq.push_back(d);
`endif
      end
    end else if (o) begin
      if (mq.size() == 0) m_unf = 1'b1;
      else void'(mq.pop_back());
    end
  endtask

  // Compare every cycle once the model is anchored by a reset.
  always @(negedge clk) begin
    if (checking) begin
      chk("model_d_out", d_out, m_top());
      chk("model_count", count, mq.size());
      chk("model_empty", empty, mq.size() == 0);
      chk("model_full", full, mq.size() == DEPTH);
      chk("model_overflow", overflow, m_ovf);
      chk("model_underflow", underflow, m_unf);
    end
  end

  // One clock: drive inputs, take the edge, advance the model, return at the falling edge.
  task automatic cyc(input bit p, input bit o, input logic [WIDTH-1:0] d, input bit r);
    push = p; pop = o; d_in = d; reset = r;
    @(posedge clk);
    model_step(p, o, d, r);
    @(negedge clk);
  endtask

  task automatic do_push(input logic [WIDTH-1:0] d); cyc(1'b1, 1'b0, d, 1'b1); endtask
  task automatic do_pop(); cyc(1'b0, 1'b1, '0, 1'b1); endtask
  task automatic do_reset(); cyc(1'b0, 1'b0, '0, 1'b0); endtask

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; d_in = '0;
    @(negedge clk);
    do_reset();
    checking = 1'b1;
    do_reset();
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_count", count, 0);
    chk("rst_d_out", d_out, 0); chk("rst_ovf", overflow, 0); chk("rst_unf", underflow, 0);

    // LIFO order
    do_push(10'h010); do_push(10'h020); do_push(10'h030);
    chk("lifo_count", count, 3); chk("lifo_top", d_out, 10'h030);
    chk("lifo_pop1", d_out, 10'h030); do_pop();
    chk("lifo_pop2", d_out, 10'h020); do_pop();
    chk("lifo_pop3", d_out, 10'h010); do_pop();
    chk("lifo_after", d_out, 0); chk("lifo_empty", empty, 1); chk("lifo_unf", underflow, 0);

    // Underflow from reset
    do_reset();
    do_pop();
    chk("unf_flag", underflow, 1); chk("unf_count", count, 0); chk("unf_d_out", d_out, 0);
    do_push(10'h055);
    chk("unf_push_top", d_out, 10'h055); chk("unf_sticky", underflow, 1);

    // Full and overflow
    do_reset();
    for (int i = 1; i <= DEPTH; i++) do_push(WIDTH'(i));
    chk("full_flag", full, 1); chk("full_ovf0", overflow, 0);
    do_push(10'h3FF);
    chk("ovf_flag", overflow, 1); chk("ovf_count", count, 8);
`ifdef PILA_WRAP_EN
    chk("ovf_top_wrap", d_out, 10'h3FF);
    chk("wrap_pop0", d_out, 10'h3FF); do_pop();
    for (int i = 8; i >= 2; i--) begin
      chk("wrap_pop", d_out, i);
      do_pop();
    end
`else
    chk("ovf_top_drop", d_out, 10'h008);
    for (int i = 8; i >= 1; i--) begin
      chk("drop_pop", d_out, i);
      do_pop();
    end
`endif
    chk("drain_empty", empty, 1); chk("drain_ovf_sticky", overflow, 1);

    // Simultaneous push+pop on a non-empty stack
    do_reset();
    do_push(10'h011); do_push(10'h022);
    cyc(1'b1, 1'b1, 10'h0AA, 1'b1);
    chk("repl_count", count, 2); chk("repl_top", d_out, 10'h0AA);
    do_pop();
    chk("repl_next", d_out, 10'h011);

    // Simultaneous push+pop on an empty stack
    do_reset();
    cyc(1'b1, 1'b1, 10'h0AA, 1'b1);
    chk("pp_empty_count", count, 1); chk("pp_empty_top", d_out, 10'h0AA);
    chk("pp_empty_unf", underflow, 0);

    // Reset mid-operation wins over push
    do_reset();
    do_push(10'h100); do_push(10'h200);
    cyc(1'b1, 1'b0, 10'h300, 1'b0);
    chk("midrst_count", count, 0); chk("midrst_empty", empty, 1);
    chk("midrst_d_out", d_out, 0); chk("midrst_ovf", overflow, 0); chk("midrst_unf", underflow, 0);
    do_pop();
    chk("midrst_unf_after", underflow, 1);

    // Mixed traffic exercising pointer wrap, checked by the model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      case (i % 5)
        0, 1, 3: do_push(WIDTH'(10'h040 + i * 7));
        2:       do_pop();
        default: cyc(1'b1, 1'b1, WIDTH'(10'h200 + i), 1'b1);
      endcase
    end
    for (int i = 0; i < 10; i++) do_pop();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
